// File: rtl/lanectrl_seq_pkg.sv
// Shared command encoding and FSM state type for the
// PF_LANECTRL TX DQS delay-line tap sequencer.
package lanectrl_seq_pkg;

   localparam logic [1:0] CMD_LOAD = 2'b00;
   localparam logic [1:0] CMD_INC  = 2'b01;
   localparam logic [1:0] CMD_DEC  = 2'b10;
   localparam logic [1:0] CMD_GOTO = 2'b11;

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_PAUSE_PRE,
      S_LOAD,
      S_PAUSE_POST,
      S_MOVE,
      S_GAP,
      S_DONE
   } state_e;

endpackage

// File: rtl/lanectrl_seq_rr_arb.sv
// Two-way round-robin arbiter; the last-winner pointer moves
// only when an operation completes.
module lanectrl_seq_rr_arb (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   input  logic upd,
   input  logic upd_b,
   output logic gnt,
   output logic gnt_b
);

   logic last_b_q;
   logic last_b_d;

   always_comb begin
      gnt      = req_a | req_b;
      gnt_b    = req_b & (~req_a | ~last_b_q);
      last_b_d = upd ? upd_b : last_b_q;
   end

   // "B served last" after reset so a tie goes to A
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_b_q <= 1'b1;
      else        last_b_q <= last_b_d;
   end

endmodule

// File: rtl/lanectrl_dly_tap_sequencer.sv
// Sequences LOAD / INC / DEC / GOTO operations on the lane TX DQS
// delay line for two round-robin requesters, tracking the tap.
module lanectrl_dly_tap_sequencer
   import lanectrl_seq_pkg::*;
#(
   parameter int TAP_W       = 7,
   parameter int TAP_MAX     = 127,
   parameter int DEFAULT_TAP = 1,
   parameter int MOVE_GAP    = 4,
   parameter int LOAD_HOLD   = 2,
   parameter int PAUSE_LEAD  = 3
) (
   input  logic             SCLK,
   input  logic             RESETN,
   input  logic             REQ_A,
   input  logic [1:0]       CMD_A,
   input  logic [TAP_W-1:0] ARG_A,
   output logic             ACK_A,
   input  logic             REQ_B,
   input  logic [1:0]       CMD_B,
   input  logic [TAP_W-1:0] ARG_B,
   output logic             ACK_B,
   output logic             STATUS_ERR,
   output logic [TAP_W-1:0] TAP_CNT,
   output logic             BUSY,
   input  logic             DELAY_LINE_OOR,
   output logic             DELAY_LINE_SEL,
   output logic             DELAY_LINE_LOAD,
   output logic             DELAY_LINE_DIRECTION,
   output logic             DELAY_LINE_MOVE,
   output logic             HS_IO_CLK_PAUSE
);

   localparam logic [TAP_W-1:0] TAP_MAX_T = TAP_W'(TAP_MAX);
   localparam logic [TAP_W:0]   TAP_MAX_X = (TAP_W+1)'(TAP_MAX);
   localparam logic [TAP_W-1:0] TAP_DEF_T = TAP_W'(DEFAULT_TAP);
   localparam logic [TAP_W-1:0] TAP_ONE   = TAP_W'(1);

   state_e           state_q, state_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [TAP_W-1:0] arg_q, arg_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [TAP_W-1:0] steps_q, steps_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             win_b_q, win_b_d;
   logic             dir_q, dir_d;
   logic             err_q, err_d;
   logic             status_q, status_d;
   logic [TAP_W:0]   sum;
   logic             gnt, gnt_b;

   lanectrl_seq_rr_arb u_arb (
      .clk   (SCLK),
      .rst_n (RESETN),
      .req_a (REQ_A),
      .req_b (REQ_B),
      .upd   (state_q == S_DONE),
      .upd_b (win_b_q),
      .gnt   (gnt),
      .gnt_b (gnt_b)
   );

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      arg_d    = arg_q;
      tap_d    = tap_q;
      steps_d  = steps_q;
      cnt_d    = cnt_q;
      win_b_d  = win_b_q;
      dir_d    = dir_q;
      err_d    = err_q;
      status_d = status_q;
      sum      = {1'b0, tap_q} + {1'b0, arg_q};
      unique case (state_q)
         S_IDLE: begin
            if (gnt) begin
               state_d = S_GRANT;
               win_b_d = gnt_b;
               cmd_d   = gnt_b ? CMD_B : CMD_A;
               arg_d   = gnt_b ? ARG_B : ARG_A;
            end
         end
         S_GRANT: begin
            err_d   = 1'b0;
            dir_d   = 1'b0;
            steps_d = '0;
            unique case (cmd_q)
               CMD_INC: begin
                  dir_d = 1'b1;
                  if (sum > TAP_MAX_X) begin
                     steps_d = TAP_MAX_T - tap_q;
                     err_d   = 1'b1;
                  end else begin
                     steps_d = arg_q;
                  end
               end
               CMD_DEC: begin
                  if (arg_q > tap_q) begin
                     steps_d = tap_q;
                     err_d   = 1'b1;
                  end else begin
                     steps_d = arg_q;
                  end
               end
               CMD_GOTO: begin
                  if ({1'b0, arg_q} > TAP_MAX_X) begin
                     err_d = 1'b1;
                  end else if (arg_q > tap_q) begin
                     dir_d   = 1'b1;
                     steps_d = arg_q - tap_q;
                  end else begin
                     steps_d = tap_q - arg_q;
                  end
               end
               CMD_LOAD: ;
            endcase
            if (cmd_q == CMD_LOAD) begin
               state_d = S_PAUSE_PRE;
               cnt_d   = CNT_W'(PAUSE_LEAD - 1);
            end else if (steps_d != '0) begin
               state_d = S_MOVE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_PAUSE_PRE: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_LOAD;
               cnt_d   = CNT_W'(LOAD_HOLD - 1);
            end
         end
         S_LOAD: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_PAUSE_POST;
               cnt_d   = CNT_W'(PAUSE_LEAD - 1);
               tap_d   = TAP_DEF_T;
            end
         end
         S_PAUSE_POST: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = S_DONE;
         end
         S_MOVE: begin
            tap_d   = dir_q ? tap_q + TAP_ONE : tap_q - TAP_ONE;
            steps_d = steps_q - TAP_ONE;
            cnt_d   = CNT_W'(MOVE_GAP - 1);
            state_d = S_GAP;
         end
         S_GAP: begin
            cnt_d = cnt_q - 1'b1;
            // the line refused the last step: undo it and stop
            if (DELAY_LINE_OOR) begin
               tap_d   = dir_q ? tap_q - TAP_ONE : tap_q + TAP_ONE;
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == '0) begin
               state_d = (steps_q != '0) ? S_MOVE : S_DONE;
            end
         end
         S_DONE: begin
            status_d = err_q;
            state_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge SCLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q  <= S_IDLE;
         cmd_q    <= CMD_LOAD;
         arg_q    <= '0;
         tap_q    <= TAP_DEF_T;
         steps_q  <= '0;
         cnt_q    <= '0;
         win_b_q  <= 1'b0;
         dir_q    <= 1'b0;
         err_q    <= 1'b0;
         status_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         arg_q    <= arg_d;
         tap_q    <= tap_d;
         steps_q  <= steps_d;
         cnt_q    <= cnt_d;
         win_b_q  <= win_b_d;
         dir_q    <= dir_d;
         err_q    <= err_d;
         status_q <= status_d;
      end
   end

   // direction is live in GRANT so MOVE always sees it set up
   always_comb begin
      BUSY                 = (state_q != S_IDLE);
      DELAY_LINE_SEL       = BUSY;
      DELAY_LINE_DIRECTION = (state_q == S_GRANT) ? dir_d :
                             (BUSY ? dir_q : 1'b0);
      DELAY_LINE_MOVE      = (state_q == S_MOVE);
      DELAY_LINE_LOAD      = (state_q == S_LOAD);
      HS_IO_CLK_PAUSE      = (state_q == S_PAUSE_PRE) ||
                             (state_q == S_LOAD) ||
                             (state_q == S_PAUSE_POST);
      ACK_A                = (state_q == S_DONE) && !win_b_q;
      ACK_B                = (state_q == S_DONE) && win_b_q;
      STATUS_ERR           = (state_q == S_DONE) ? err_q : status_q;
      TAP_CNT              = tap_q;
   end

endmodule

// File: tb/tb_lanectrl_dly_tap_sequencer.sv
// Directed bench for the delay-line tap sequencer: vector table
// of single operations plus reset and arbitration sequences.
module tb_lanectrl_dly_tap_sequencer;
   import lanectrl_seq_pkg::*;

   logic       SCLK = 1'b0;
   logic       RESETN = 1'b0;
   logic       REQ_A = 1'b0, REQ_B = 1'b0;
   logic [1:0] CMD_A = 2'b00, CMD_B = 2'b00;
   logic [6:0] ARG_A = '0, ARG_B = '0;
   logic       ACK_A, ACK_B, STATUS_ERR, BUSY;
   logic [6:0] TAP_CNT;
   logic       DELAY_LINE_OOR = 1'b0;
   logic       DELAY_LINE_SEL, DELAY_LINE_LOAD;
   logic       DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
   logic       HS_IO_CLK_PAUSE;

   int checks = 0;
   int errors = 0;

   lanectrl_dly_tap_sequencer dut (
      .SCLK                 (SCLK),
      .RESETN               (RESETN),
      .REQ_A                (REQ_A),
      .CMD_A                (CMD_A),
      .ARG_A                (ARG_A),
      .ACK_A                (ACK_A),
      .REQ_B                (REQ_B),
      .CMD_B                (CMD_B),
      .ARG_B                (ARG_B),
      .ACK_B                (ACK_B),
      .STATUS_ERR           (STATUS_ERR),
      .TAP_CNT              (TAP_CNT),
      .BUSY                 (BUSY),
      .DELAY_LINE_OOR       (DELAY_LINE_OOR),
      .DELAY_LINE_SEL       (DELAY_LINE_SEL),
      .DELAY_LINE_LOAD      (DELAY_LINE_LOAD),
      .DELAY_LINE_DIRECTION (DELAY_LINE_DIRECTION),
      .DELAY_LINE_MOVE      (DELAY_LINE_MOVE),
      .HS_IO_CLK_PAUSE      (HS_IO_CLK_PAUSE)
   );

   always #5 SCLK = ~SCLK;

   typedef struct {
      int use_b;
      int cmd;
      int arg;
      int oor_at;
      int moves;
      int dir;
      int tap;
      int err;
      int lat;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs();
      return int'({BUSY, DELAY_LINE_SEL, DELAY_LINE_LOAD,
                   DELAY_LINE_DIRECTION, DELAY_LINE_MOVE,
                   HS_IO_CLK_PAUSE, ACK_A, ACK_B, STATUS_ERR});
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      int c = 0, moves = 0, pause_n = 0, load_n = 0;
      int load_first = -1, dir_bad = 0, sel_bad = 0;
      int wrong = 0, lat = -1;
      @(negedge SCLK);
      if (v.use_b != 0) begin
         REQ_B = 1'b1; CMD_B = 2'(v.cmd); ARG_B = 7'(v.arg);
      end else begin
         REQ_A = 1'b1; CMD_A = 2'(v.cmd); ARG_A = 7'(v.arg);
      end
      while (lat < 0 && c < 1000) begin
         @(negedge SCLK);
         c++;
         if (DELAY_LINE_MOVE) begin
            moves++;
            if (DELAY_LINE_DIRECTION !== 1'(v.dir)) dir_bad++;
         end
         if (HS_IO_CLK_PAUSE) pause_n++;
         if (DELAY_LINE_LOAD) begin
            if (load_n == 0) load_first = pause_n;
            load_n++;
         end
         if (!DELAY_LINE_SEL || !BUSY) sel_bad++;
         if (v.oor_at != 0 && DELAY_LINE_MOVE && moves == v.oor_at)
            DELAY_LINE_OOR = 1'b1;
         if (ACK_A || ACK_B) begin
            lat = c;
            if (ACK_A !== (v.use_b == 0) || ACK_B !== (v.use_b != 0))
               wrong++;
            chk({tag, " err_at_ack"}, int'(STATUS_ERR), v.err);
            REQ_A = 1'b0;
            REQ_B = 1'b0;
            DELAY_LINE_OOR = 1'b0;
         end
      end
      chk({tag, " latency"}, lat, v.lat);
      chk({tag, " moves"}, moves, v.moves);
      chk({tag, " tap"}, int'(TAP_CNT), v.tap);
      chk({tag, " dir_bad"}, dir_bad, 0);
      chk({tag, " sel_bad"}, sel_bad, 0);
      chk({tag, " ack_owner"}, wrong, 0);
      chk({tag, " pause_cycles"}, pause_n, v.cmd == 0 ? 8 : 0);
      chk({tag, " load_cycles"}, load_n, v.cmd == 0 ? 2 : 0);
      if (v.cmd == 0) chk({tag, " load_pos"}, load_first, 4);
      @(negedge SCLK);
      chk({tag, " err_held"}, int'(STATUS_ERR), v.err);
      chk({tag, " idle"}, int'(BUSY), 0);
   endtask

   initial begin
      int c, acks, a_at, b_at, both;
      vec_t v;

      //          b cmd arg oor mv dir tap err lat
      vecs[0]  = '{0, 1, 3,   0, 3,   1, 4,   0, 17};
      vecs[1]  = '{0, 3, 0,   0, 4,   0, 0,   0, 22};
      vecs[2]  = '{1, 1, 50,  0, 50,  1, 50,  0, 252};
      vecs[3]  = '{1, 0, 9,   0, 0,   0, 1,   0, 10};
      vecs[4]  = '{0, 3, 125, 0, 124, 1, 125, 0, 622};
      vecs[5]  = '{0, 1, 10,  0, 2,   1, 127, 1, 12};
      vecs[6]  = '{0, 2, 0,   0, 0,   0, 127, 0, 2};
      vecs[7]  = '{1, 2, 5,   0, 5,   0, 122, 0, 27};
      vecs[8]  = '{0, 1, 5,   2, 2,   1, 123, 1, 9};
      vecs[9]  = '{0, 3, 2,   0, 121, 0, 2,   0, 607};
      vecs[10] = '{0, 2, 5,   0, 2,   0, 0,   1, 12};

      repeat (3) @(negedge SCLK);
      chk("reset outs", outs(), 0);
      chk("reset tap", int'(TAP_CNT), 1);
      RESETN = 1'b1;

      for (int i = 0; i < 11; i++)
         run_op(vecs[i], $sformatf("vec%0d", i));

      // reset in the middle of a GAP
      @(negedge SCLK);
      REQ_A = 1'b1; CMD_A = CMD_INC; ARG_A = 7'd5;
      repeat (3) @(negedge SCLK);
      chk("pre-reset tap", int'(TAP_CNT), 1);
      #2 RESETN = 1'b0;
      #1;
      chk("midgap reset outs", outs(), 0);
      chk("midgap reset tap", int'(TAP_CNT), 1);
      REQ_A = 1'b0;
      repeat (2) @(negedge SCLK);
      RESETN = 1'b1;
      acks = 0;
      repeat (30) begin
         @(negedge SCLK);
         if (ACK_A || ACK_B || BUSY) acks++;
      end
      chk("no ack after reset", acks, 0);

      v = '{1, 1, 2, 0, 2, 1, 3, 0, 12};
      run_op(v, "post-reset");

      // simultaneous requests: A first (B served last), then B
      @(negedge SCLK);
      REQ_A = 1'b1; CMD_A = CMD_INC; ARG_A = 7'd2;
      REQ_B = 1'b1; CMD_B = CMD_INC; ARG_B = 7'd3;
      c = 0; a_at = -1; b_at = -1; both = 0;
      while (b_at < 0 && c < 200) begin
         @(negedge SCLK);
         c++;
         if (ACK_A && ACK_B) both++;
         if (ACK_A) begin
            a_at = c;
            REQ_A = 1'b0;
            chk("arb tap after A", int'(TAP_CNT), 5);
         end
         if (ACK_B) begin
            b_at = c;
            REQ_B = 1'b0;
            chk("arb tap after B", int'(TAP_CNT), 8);
            chk("arb err", int'(STATUS_ERR), 0);
         end
      end
      chk("arb A ack cycle", a_at, 12);
      chk("arb B ack cycle", b_at, 30);
      chk("arb double ack", both, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/lanectrl_dly_tap_sequencer.md
Name: lanectrl_dly_tap_sequencer

Overview:
- Controller that sequences the TX DQS delay line of a PF_LANECTRL lane: LOAD-to-default, relative INC/DEC, and absolute GOTO tap operations.
- Drives DELAY_LINE_SEL/LOAD/DIRECTION/MOVE and the pre-sync HS_IO_CLK_PAUSE request.
- Arbitrates round-robin between two requesters: A (bit-align training engine) and B (debug/user register interface).
- Tracks the current tap and reports range errors.

Parameters:
- TAP_W, 7, tap counter width.
- TAP_MAX, 127, highest legal tap.
- DEFAULT_TAP, 1, tap value after LOAD and after reset; equals the lane TX_DQS_DELAY_VAL.
- MOVE_GAP, 4, idle cycles after each MOVE pulse.
- LOAD_HOLD, 2, cycles LOAD is held high.
- PAUSE_LEAD, 3, cycles HS_IO_CLK_PAUSE is held before LOAD and again after it.

Ports:
- SCLK  in  1  fabric clock; single clock domain.
- RESETN  in  1  asynchronous active-low reset.
- REQ_A  in  1  requester A request; held until ACK_A.
- CMD_A  in  2  00 LOAD, 01 INC, 10 DEC, 11 GOTO.
- ARG_A  in  TAP_W  step count (INC/DEC) or target tap (GOTO); ignored for LOAD.
- ACK_A  out  1  one-cycle completion pulse.
- REQ_B, CMD_B, ARG_B, ACK_B  as for A.
- STATUS_ERR  out  1  error result of the last completed operation.
- TAP_CNT  out  TAP_W  current tracked tap.
- BUSY  out  1  high in any state other than IDLE.
- DELAY_LINE_OOR  in  1  from LANECTRL TX_DELAY_LINE_OUT_OF_RANGE.
- DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE  out  1 each  to LANECTRL.
- HS_IO_CLK_PAUSE  out  1  to the lane pause synchroniser.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - All outputs 0, TAP_CNT=DEFAULT_TAP, state IDLE, round-robin pointer favours A.
  - An operation in progress is discarded; no ACK is issued.
- States: IDLE, GRANT, PAUSE_PRE, LOAD, PAUSE_POST, MOVE, GAP, DONE.
- Arbitration:
  - Requests are sampled only in IDLE.
  - If both requesters are high, the one not served last wins; otherwise the single requester wins.
  - The winner's CMD/ARG are latched at entry to GRANT (cycle t0+1, where t0 is the sampling cycle).
- GRANT (1 cycle):
  - Computes the step count N and the direction.
  - INC: N=ARG, DIR=1. DEC: N=ARG, DIR=0. GOTO: N=|ARG-TAP_CNT|, DIR=(ARG>TAP_CNT).
  - DIR=1 means more delay.
  - INC clamp: if TAP_CNT+ARG > TAP_MAX, N is reduced to TAP_MAX-TAP_CNT and the error flag is set.
  - DEC clamp: if ARG > TAP_CNT, N=TAP_CNT and the error flag is set.
  - GOTO with ARG>TAP_MAX: N=0, error flag set.
  - Next state: MOVE if N>0, DONE if N=0, PAUSE_PRE for LOAD.
- DELAY_LINE_SEL is high from GRANT through DONE inclusive.
- DELAY_LINE_DIRECTION is driven from GRANT and held through DONE, giving at least 1 cycle of setup before the first MOVE.
- MOVE (1 cycle):
  - DELAY_LINE_MOVE=1; TAP_CNT += or -= 1 on that edge.
  - Then GAP for MOVE_GAP cycles; after the gap, return to MOVE if steps remain, else DONE.
- DELAY_LINE_OOR:
  - Sampled in every GAP cycle.
  - If high: revert the last TAP_CNT update, set the error flag, go to DONE.
- LOAD sequence:
  - PAUSE_PRE: PAUSE=1 for PAUSE_LEAD cycles.
  - LOAD: LOAD=1 and PAUSE=1 for LOAD_HOLD cycles.
  - PAUSE_POST: PAUSE=1 for PAUSE_LEAD cycles.
  - Then DONE; TAP_CNT=DEFAULT_TAP on exit from the LOAD state.
- DONE (1 cycle):
  - Pulses the winner's ACK; STATUS_ERR is updated to the error flag.
  - Next state IDLE; the pointer records the winner.
- STATUS_ERR is held until the next DONE.
- Latencies, with ACK asserted in the cycle shown:
  - INC/DEC/GOTO with N steps: ACK at t0+2+N*(1+MOVE_GAP).
  - N=0: ACK at t0+2.
  - LOAD: ACK at t0+2+2*PAUSE_LEAD+LOAD_HOLD.
- Protocol rules:
  - A request dropped before ACK does not abort the operation; ACK still pulses.
  - A REQ still high in the cycle after ACK is treated as a new request.
  - Back-to-back operations are separated by at least one IDLE cycle.

Decomposition:
- Package lanectrl_seq_pkg: command encoding constants (CMD_LOAD, CMD_INC, CMD_DEC, CMD_GOTO) and the state enum.
- One sub-module: lanectrl_seq_rr_arb, a two-way round-robin arbiter with a last-winner pointer, updated only on DONE.

Test Plan:
- Reset, then A: INC ARG=3 (MOVE_GAP=4) -> 3 MOVE pulses 5 cycles apart with DIRECTION=1; TAP_CNT 1->4; ACK_A at t0+17; STATUS_ERR=0.
- GOTO ARG=0 from TAP_CNT=4 -> 4 MOVE pulses with DIRECTION=0; TAP_CNT=0; ACK at t0+22.
- A and B request together in IDLE twice in a row -> first grant to A, second to B; each ACK goes only to its own requester.
- LOAD from TAP_CNT=50 -> PAUSE high for 8 cycles, LOAD high in cycles 4-5 of that window; TAP_CNT=1; ACK at t0+10.
- INC ARG=10 at TAP_CNT=125 -> only 2 MOVE pulses; TAP_CNT=127; STATUS_ERR=1. Separately, DELAY_LINE_OOR forced high after MOVE 2 of an INC 5 -> TAP_CNT net +1; early ACK; STATUS_ERR=1.
- RESETN asserted in the middle of a GAP -> outputs 0 in the same cycle; TAP_CNT=1; no ACK; after release, the next request runs normally.
